mem_port_arbiter: RTL

- Shares the single data-memory port behind the LSU between two requesters:
  - the core load/store path;
  - a debug/program-loader master, used for halt-time loads and inspection.
- Issues at most one memory command per cycle and routes 1-cycle-latency read data back to the correct owner.
- Round-robin fairness, plus a debug lock mode for atomic multi-word loader sequences.

---
 rtl/mem_arb_pkg.sv | 31 +++
 rtl/mem_port_arbiter_rr_arb2.sv | 33 +++
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the data-memory port arbiter: FSM states, requester ids
// and the muxed memory command bundle.
package mem_arb_pkg;

  localparam int unsigned CMD_ADDR_W = 32;
  localparam int unsigned CMD_DATA_W = 32;
  localparam int unsigned CMD_MASK_W = CMD_DATA_W / 8;

  typedef enum logic {
    ARB      = 1'b0,
    DBG_LOCK = 1'b1
  } arb_state_e;

  typedef enum logic {
    REQ_CORE = 1'b0,
    REQ_DBG  = 1'b1
  } requester_e;

  typedef struct packed {
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] wdata;
    logic                  wren;
    logic [CMD_MASK_W-1:0] bmask;
  } mem_cmd_t;

  // Loser of a two-way grant; used as the next round-robin priority.
  function automatic requester_e loser_of(input logic [1:0] gnt);
    return gnt[0] ? REQ_DBG : REQ_CORE;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant from the request pair and a
// registered priority pointer that hands priority to whoever lost last time.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       force_core,
  output logic [1:0] gnt
);

  requester_e ptr;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (ptr == REQ_CORE) ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= REQ_CORE;
    end else if (force_core) begin
      ptr <= REQ_CORE;
    end else if (update && (gnt != 2'b00)) begin
      ptr <= loser_of(gnt);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the LSU data-memory port between the core and the debug/loader
// master: round-robin arbitration, debug lock mode, 1-cycle response routing.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = CMD_ADDR_W,
  parameter int unsigned DATA_W = CMD_DATA_W
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_core_req,
  input  logic [ADDR_W-1:0]   i_core_addr,
  input  logic [DATA_W-1:0]   i_core_wdata,
  input  logic                i_core_wren,
  input  logic [DATA_W/8-1:0] i_core_bmask,
  output logic                o_core_gnt,
  output logic                o_core_rvld,
  output logic [DATA_W-1:0]   o_core_rdata,
  input  logic                i_dbg_req,
  input  logic [ADDR_W-1:0]   i_dbg_addr,
  input  logic [DATA_W-1:0]   i_dbg_wdata,
  input  logic                i_dbg_wren,
  input  logic [DATA_W/8-1:0] i_dbg_bmask,
  input  logic                i_dbg_lock,
  output logic                o_dbg_gnt,
  output logic                o_dbg_rvld,
  output logic [DATA_W-1:0]   o_dbg_rdata,
  output logic                o_mem_en,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic                o_mem_wren,
  output logic [DATA_W/8-1:0] o_mem_bmask,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  output logic                o_locked
);

  arb_state_e state;
  logic       locked_q;
  logic       rsp_vld_q;
  requester_e rsp_owner_q;

  logic [1:0] rr_gnt;
  logic       core_gnt;
  logic       dbg_gnt;
  logic       rsp_live;
  mem_cmd_t   core_cmd;
  mem_cmd_t   dbg_cmd;
  mem_cmd_t   mem_cmd;

  rr_arb2 u_rr_arb2 (
    .clk        (i_clk),
    .reset      (i_reset),
    .req        ({i_dbg_req, i_core_req}),
    .update     (state == ARB),
    .force_core ((state == DBG_LOCK) && !i_dbg_lock),
    .gnt        (rr_gnt)
  );

  // The round-robin result only applies in ARB; in DBG_LOCK debug owns the port.
  always_comb begin
    core_gnt = 1'b0;
    dbg_gnt  = 1'b0;
    if (!i_reset) begin
      if (state == ARB) begin
        core_gnt = rr_gnt[0];
        dbg_gnt  = rr_gnt[1];
      end else begin
        dbg_gnt  = i_dbg_req;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= ARB;
      locked_q <= 1'b0;
    end else begin
      case (state)
        ARB: begin
          if (dbg_gnt && i_dbg_lock) begin
            state    <= DBG_LOCK;
            locked_q <= 1'b1;
          end
        end
        DBG_LOCK: begin
          if (!i_dbg_lock) begin
            state    <= ARB;
            locked_q <= 1'b0;
          end
        end
        default: begin
          state    <= ARB;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rsp_vld_q   <= 1'b0;
      rsp_owner_q <= REQ_CORE;
    end else begin
      rsp_vld_q   <= (core_gnt && !i_core_wren) || (dbg_gnt && !i_dbg_wren);
      rsp_owner_q <= dbg_gnt ? REQ_DBG : REQ_CORE;
    end
  end

  assign core_cmd = '{addr: i_core_addr, wdata: i_core_wdata,
                      wren: i_core_wren, bmask: i_core_bmask};
  assign dbg_cmd  = '{addr: i_dbg_addr, wdata: i_dbg_wdata,
                      wren: i_dbg_wren, bmask: i_dbg_bmask};

  always_comb begin
    mem_cmd = '0;
    if (core_gnt) begin
      mem_cmd = core_cmd;
    end else if (dbg_gnt) begin
      mem_cmd = dbg_cmd;
    end
  end

  assign o_core_gnt  = core_gnt;
  assign o_dbg_gnt   = dbg_gnt;
  assign o_mem_en    = core_gnt | dbg_gnt;
  assign o_mem_addr  = mem_cmd.addr;
  assign o_mem_wdata = mem_cmd.wdata;
  assign o_mem_wren  = mem_cmd.wren;
  assign o_mem_bmask = mem_cmd.bmask;
  assign o_locked    = locked_q & ~i_reset;

  // Gating with reset drops any response still pending when reset arrives.
  assign rsp_live     = rsp_vld_q & ~i_reset;
  assign o_core_rvld  = rsp_live && (rsp_owner_q == REQ_CORE);
  assign o_dbg_rvld   = rsp_live && (rsp_owner_q == REQ_DBG);
  assign o_core_rdata = o_core_rvld ? i_mem_rdata : '0;
  assign o_dbg_rdata  = o_dbg_rvld ? i_mem_rdata : '0;

  a_one_gnt : assert property (@(posedge i_clk) !(o_core_gnt && o_dbg_gnt));
  a_one_rvld : assert property (@(posedge i_clk) !(o_core_rvld && o_dbg_rvld));
  a_lock_no_core : assert property (@(posedge i_clk) o_locked |-> !o_core_gnt);

endmodule
